// File: rtl/ooo_rename_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : ooo_rename_pkg
// Description : Shared types and constants for the rename scheduler slice.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

`ifndef ARCH_REG_NUM_WIDTH
`define ARCH_REG_NUM_WIDTH 5
`endif

`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif

package ooo_rename_pkg;

    typedef logic [`ARCH_REG_NUM_WIDTH-1:0]     arch_reg_t;
    typedef logic [`PHYSICAL_REG_NUM_WIDTH-1:0] phy_reg_t;

    // Front-side sequencing state: running, waiting on the free list,
    // or waiting on dispatch back-pressure.
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        STALL_FL  = 2'd1,
        STALL_DIS = 2'd2
    } rs_state_t;

    // Architectural x0 is hard-wired and never receives a physical register.
    localparam arch_reg_t ZERO_REG = '0;

endpackage

`default_nettype wire

// File: rtl/rename_commit_q.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : rename_commit_q
// Description : Dual-push / single-pop FIFO that serializes ROB commits onto
//               the rename file's single commit port. Registered outputs.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module rename_commit_q
    import ooo_rename_pkg::*;
#(
    parameter int PHYSICAL_REG_NUM_WIDTH = `PHYSICAL_REG_NUM_WIDTH,
    parameter int COMMIT_Q_DEPTH         = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [1:0]                        push_en,
    input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] push_reg0,
    input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] push_reg1,
    output logic                              push_ready,
    output logic                              cm_valid,
    output logic                              cm_with_write,
    output logic [PHYSICAL_REG_NUM_WIDTH-1:0] cm_reg
);

    localparam int c_PTR_W = $clog2(COMMIT_Q_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [PHYSICAL_REG_NUM_WIDTH-1:0] r_mem [COMMIT_Q_DEPTH];
    logic [c_PTR_W-1:0]                r_wr_ptr;
    logic [c_PTR_W-1:0]                r_rd_ptr;
    logic [c_CNT_W-1:0]                r_count;
    logic                              r_cm_valid;
    logic                              r_cm_with_write;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] r_cm_reg;

    logic [c_CNT_W-1:0] w_free;
    logic               w_ready;
    logic               w_push0;
    logic               w_push1;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_num_push;
    logic [c_PTR_W-1:0] w_wr_ptr1;

    // Room for a full two-wide commit is judged on the registered count only.
    assign w_free     = c_CNT_W'(COMMIT_Q_DEPTH) - r_count;
    assign w_ready    = (w_free >= c_CNT_W'(2));
    assign w_push0    = w_ready && push_en[0];
    assign w_push1    = w_ready && push_en[1];
    assign w_pop      = (r_count != '0);
    assign w_num_push = c_CNT_W'(w_push0) + c_CNT_W'(w_push1);
    // Slot 1 lands right behind slot 0 when both push, otherwise at the tail.
    assign w_wr_ptr1  = r_wr_ptr + c_PTR_W'(w_push0);

    assign push_ready    = w_ready;
    assign cm_valid      = r_cm_valid;
    assign cm_with_write = r_cm_with_write;
    assign cm_reg        = r_cm_reg;

    // Storage array: no reset needed, validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_push0) begin
            r_mem[r_wr_ptr] <= push_reg0;
        end
        if (w_push1) begin
            r_mem[w_wr_ptr1] <= push_reg1;
        end
    end

    // Pointers, occupancy and the registered commit-port outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_cm_valid      <= 1'b0;
            r_cm_with_write <= 1'b0;
            r_cm_reg        <= '0;
        end else begin
            r_wr_ptr        <= r_wr_ptr + c_PTR_W'(w_num_push);
            r_rd_ptr        <= r_rd_ptr + c_PTR_W'(w_pop);
            r_count         <= r_count + w_num_push - c_CNT_W'(w_pop);
            r_cm_valid      <= w_pop;
            r_cm_with_write <= w_pop;
            if (w_pop) begin
                r_cm_reg <= r_mem[r_rd_ptr];
            end
        end
    end

    // A push into a full queue would silently overwrite the oldest entry.
    always @(posedge clk) begin
        if (!reset) begin
            a_no_overflow: assert (!((r_count == c_CNT_W'(COMMIT_Q_DEPTH)) && (w_push0 || w_push1)));
        end
    end

endmodule

`default_nettype wire

// File: rtl/rename_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : rename_sched
// Description : Sequences rename requests between decode and dispatch, and
//               serializes two-wide ROB commits onto the rename commit port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module rename_sched
    import ooo_rename_pkg::*;
#(
    parameter int ARCH_REG_NUM_WIDTH     = `ARCH_REG_NUM_WIDTH,
    parameter int PHYSICAL_REG_NUM_WIDTH = `PHYSICAL_REG_NUM_WIDTH,
    parameter int COMMIT_Q_DEPTH         = 4,
    parameter int STALL_CNT_WIDTH        = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    // decode side
    input  logic                                dec_valid,
    output logic                                dec_ready,
    input  logic [ARCH_REG_NUM_WIDTH-1:0]       dec_rs1,
    input  logic [ARCH_REG_NUM_WIDTH-1:0]       dec_rs2,
    input  logic [ARCH_REG_NUM_WIDTH-1:0]       dec_rd,
    input  logic                                dec_regwrite,
    // rename file
    output logic [ARCH_REG_NUM_WIDTH-1:0]       rf_read1,
    output logic [ARCH_REG_NUM_WIDTH-1:0]       rf_read2,
    output logic [ARCH_REG_NUM_WIDTH-1:0]       rf_write,
    output logic                                rf_regwrite,
    input  logic [PHYSICAL_REG_NUM_WIDTH-1:0]   rf_prs1,
    input  logic [PHYSICAL_REG_NUM_WIDTH-1:0]   rf_prs2,
    input  logic [PHYSICAL_REG_NUM_WIDTH-1:0]   rf_prd,
    input  logic                                rf_valid,
    // dispatch side
    output logic                                dis_valid,
    input  logic                                dis_ready,
    output logic [PHYSICAL_REG_NUM_WIDTH-1:0]   dis_prs1,
    output logic [PHYSICAL_REG_NUM_WIDTH-1:0]   dis_prs2,
    output logic [PHYSICAL_REG_NUM_WIDTH-1:0]   dis_prd,
    output logic                                dis_regwrite,
    // ROB commit side
    input  logic [1:0]                          rob_cm_valid,
    input  logic [1:0]                          rob_cm_with_write,
    input  logic [2*PHYSICAL_REG_NUM_WIDTH-1:0] rob_cm_reg,
    output logic                                rob_cm_ready,
    output logic                                cm_valid,
    output logic                                cm_with_write,
    output logic [PHYSICAL_REG_NUM_WIDTH-1:0]   cm_reg,
    output logic [STALL_CNT_WIDTH-1:0]          stall_cnt
);

    logic                              r_dis_valid;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] r_dis_prs1;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] r_dis_prs2;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] r_dis_prd;
    logic                              r_dis_regwrite;
    rs_state_t                         r_state;
    logic [STALL_CNT_WIDTH-1:0]        r_stall_cnt;

    logic w_write;
    logic w_slot_free;
    logic w_can_fire;
    logic w_fire;

    // x0 destinations look like non-writes so they never consume a free reg.
    assign w_write     = dec_regwrite && (dec_rd != ARCH_REG_NUM_WIDTH'(ZERO_REG));
    assign w_slot_free = !r_dis_valid || dis_ready;
    assign w_can_fire  = w_slot_free && (!w_write || rf_valid) && !flush;
    assign w_fire      = dec_valid && w_can_fire;

    assign dec_ready   = w_can_fire;
    // The rename file pops its free list on this strobe, so it is fire-gated.
    assign rf_regwrite = w_fire && w_write;
    assign rf_read1    = dec_rs1;
    assign rf_read2    = dec_rs2;
    assign rf_write    = dec_rd;

    assign dis_valid    = r_dis_valid;
    assign dis_prs1     = r_dis_prs1;
    assign dis_prs2     = r_dis_prs2;
    assign dis_prd      = r_dis_prd;
    assign dis_regwrite = r_dis_regwrite;
    assign stall_cnt    = r_stall_cnt;

    // Dispatch output register: load on fire, drop when drained or flushed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dis_valid    <= 1'b0;
            r_dis_prs1     <= '0;
            r_dis_prs2     <= '0;
            r_dis_prd      <= '0;
            r_dis_regwrite <= 1'b0;
        end else if (flush) begin
            r_dis_valid <= 1'b0;
        end else if (w_fire) begin
            r_dis_valid    <= 1'b1;
            r_dis_prs1     <= rf_prs1;
            r_dis_prs2     <= rf_prs2;
            r_dis_prd      <= rf_prd;
            r_dis_regwrite <= w_write;
        end else if (w_slot_free) begin
            r_dis_valid <= 1'b0;
        end
    end

    // Stall FSM with its saturating residency counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RUN;
            r_stall_cnt <= '0;
        end else begin
            if ((r_state != RUN) && (r_stall_cnt != {STALL_CNT_WIDTH{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + STALL_CNT_WIDTH'(1);
            end
            if (flush || w_fire) begin
                r_state <= RUN;
            end else if (dec_valid) begin
                case (r_state)
                    RUN: begin
                        if (w_write && !rf_valid) begin
                            r_state <= STALL_FL;
                        end else if (!w_slot_free) begin
                            r_state <= STALL_DIS;
                        end
                    end
                    STALL_FL: begin
                        if (rf_valid) begin
                            r_state <= RUN;
                        end
                    end
                    STALL_DIS: begin
                        if (dis_ready) begin
                            r_state <= RUN;
                        end
                    end
                    default: r_state <= RUN;
                endcase
            end
        end
    end

    rename_commit_q #(
        .PHYSICAL_REG_NUM_WIDTH (PHYSICAL_REG_NUM_WIDTH),
        .COMMIT_Q_DEPTH         (COMMIT_Q_DEPTH)
    ) u_commit_q (
        .clk           (clk),
        .reset         (reset),
        .push_en       (rob_cm_valid & rob_cm_with_write),
        .push_reg0     (rob_cm_reg[PHYSICAL_REG_NUM_WIDTH-1:0]),
        .push_reg1     (rob_cm_reg[2*PHYSICAL_REG_NUM_WIDTH-1:PHYSICAL_REG_NUM_WIDTH]),
        .push_ready    (rob_cm_ready),
        .cm_valid      (cm_valid),
        .cm_with_write (cm_with_write),
        .cm_reg        (cm_reg)
    );

endmodule

`default_nettype wire

// File: tb/tb_rename_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_rename_sched
// Description : Self-checking bench for rename_sched with a rename-file model
//               and a transaction-level reference of the scheduler.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_rename_sched;

    localparam int c_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_regwrite;
    logic [4:0]  rf_read1, rf_read2, rf_write;
    logic        rf_regwrite;
    logic [5:0]  rf_prs1, rf_prs2, rf_prd;
    logic        rf_valid;
    logic        dis_valid;
    logic        dis_ready;
    logic [5:0]  dis_prs1, dis_prs2, dis_prd;
    logic        dis_regwrite;
    logic [1:0]  rob_cm_valid, rob_cm_with_write;
    logic [11:0] rob_cm_reg;
    logic        rob_cm_ready;
    logic        cm_valid, cm_with_write;
    logic [5:0]  cm_reg;
    logic [15:0] stall_cnt;

    rename_sched dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .dec_valid         (dec_valid),
        .dec_ready         (dec_ready),
        .dec_rs1           (dec_rs1),
        .dec_rs2           (dec_rs2),
        .dec_rd            (dec_rd),
        .dec_regwrite      (dec_regwrite),
        .rf_read1          (rf_read1),
        .rf_read2          (rf_read2),
        .rf_write          (rf_write),
        .rf_regwrite       (rf_regwrite),
        .rf_prs1           (rf_prs1),
        .rf_prs2           (rf_prs2),
        .rf_prd            (rf_prd),
        .rf_valid          (rf_valid),
        .dis_valid         (dis_valid),
        .dis_ready         (dis_ready),
        .dis_prs1          (dis_prs1),
        .dis_prs2          (dis_prs2),
        .dis_prd           (dis_prd),
        .dis_regwrite      (dis_regwrite),
        .rob_cm_valid      (rob_cm_valid),
        .rob_cm_with_write (rob_cm_with_write),
        .rob_cm_reg        (rob_cm_reg),
        .rob_cm_ready      (rob_cm_ready),
        .cm_valid          (cm_valid),
        .cm_with_write     (cm_with_write),
        .cm_reg            (cm_reg),
        .stall_cnt         (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Rename file environment: arch->phy map and free list.
    int map [32];
    int fl [$];

    // Reference model state.
    bit m_dv, m_rw, m_cmv;
    int m_p1, m_p2, m_pd, m_cmr, m_st, m_stall;
    int cq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dv = 0; m_rw = 0; m_p1 = 0; m_p2 = 0; m_pd = 0;
        m_st = 0; m_stall = 0; m_cmv = 0; m_cmr = 0;
        cq.delete();
    endtask

    // One clock of stimulus: drive inputs, check combinational outputs,
    // advance the model across the edge, then check registered outputs.
    task automatic step(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input bit rw, input bit dr, input bit fls,
                        input logic [1:0] cv, input logic [1:0] cw,
                        input logic [5:0] c0, input logic [5:0] c1);
        bit wr, rfv, slot, rdy, fire, cmr;
        int prd, p1, p2;
        dec_valid = v; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; dec_regwrite = rw;
        dis_ready = dr; flush = fls;
        rob_cm_valid = cv; rob_cm_with_write = cw; rob_cm_reg = {c1, c0};
        wr   = rw && (rd != 5'd0);
        rfv  = (fl.size() != 0);
        prd  = rfv ? fl[0] : 0;
        p1   = map[rs1];
        p2   = map[rs2];
        rf_valid = rfv; rf_prd = 6'(prd); rf_prs1 = 6'(p1); rf_prs2 = 6'(p2);
        slot = !m_dv || dr;
        rdy  = slot && (!wr || rfv) && !fls;
        fire = v && rdy;
        cmr  = (c_DEPTH - cq.size()) >= 2;
        #1;
        chk("dec_ready",    32'(dec_ready),    32'(rdy));
        chk("rf_regwrite",  32'(rf_regwrite),  32'(fire && wr));
        chk("rf_read1",     32'(rf_read1),     32'(rs1));
        chk("rf_read2",     32'(rf_read2),     32'(rs2));
        chk("rf_write",     32'(rf_write),     32'(rd));
        chk("rob_cm_ready", 32'(rob_cm_ready), 32'(cmr));
        @(posedge clk);
        n_vec++;
        if (m_st != 0 && m_stall != 32'hFFFF) m_stall++;
        if (fls || fire) m_st = 0;
        else if (v) begin
            if (m_st == 0) begin
                if (wr && !rfv) m_st = 1;
                else if (!slot) m_st = 2;
            end else if (m_st == 1) begin
                if (rfv) m_st = 0;
            end else begin
                if (dr) m_st = 0;
            end
        end
        if (fls) m_dv = 0;
        else if (fire) begin
            m_dv = 1; m_p1 = p1; m_p2 = p2; m_pd = prd; m_rw = wr;
        end else if (slot) m_dv = 0;
        if (fire && wr) begin
            map[rd] = prd;
            void'(fl.pop_front());
        end
        if (m_cmv) fl.push_back(m_cmr);
        if (cq.size() != 0) begin
            m_cmv = 1; m_cmr = cq.pop_front();
        end else m_cmv = 0;
        if (cmr) begin
            if (cv[0] && cw[0]) cq.push_back(int'(c0));
            if (cv[1] && cw[1]) cq.push_back(int'(c1));
        end
        #1;
        chk("dis_valid", 32'(dis_valid), 32'(m_dv));
        if (m_dv) begin
            chk("dis_prs1",     32'(dis_prs1),     32'(m_p1));
            chk("dis_prs2",     32'(dis_prs2),     32'(m_p2));
            chk("dis_prd",      32'(dis_prd),      32'(m_pd));
            chk("dis_regwrite", 32'(dis_regwrite), 32'(m_rw));
        end
        chk("cm_valid",      32'(cm_valid),      32'(m_cmv));
        chk("cm_with_write", 32'(cm_with_write), 32'(m_cmv));
        if (m_cmv) chk("cm_reg", 32'(cm_reg), 32'(m_cmr));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    endtask

    task automatic idle_inputs();
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_regwrite = 0;
        dis_ready = 1; flush = 0; rob_cm_valid = 0; rob_cm_with_write = 0; rob_cm_reg = 0;
    endtask

    initial begin
        int exp_cm [4];
        exp_cm = '{40, 41, 42, 43};
        for (int i = 0; i < 32; i++) map[i] = i;
        for (int i = 32; i < 64; i++) fl.push_back(i);
        model_reset();
        idle_inputs();
        rf_valid = 1; rf_prd = 6'd32; rf_prs1 = 0; rf_prs2 = 0;
        reset = 1;
        #12;
        chk("rst_dis_valid",    32'(dis_valid),    32'd0);
        chk("rst_dis_prd",      32'(dis_prd),      32'd0);
        chk("rst_dis_regwrite", 32'(dis_regwrite), 32'd0);
        chk("rst_cm_valid",     32'(cm_valid),     32'd0);
        chk("rst_cm_reg",       32'(cm_reg),       32'd0);
        chk("rst_stall_cnt",    32'(stall_cnt),    32'd0);
        chk("rst_rob_cm_ready", 32'(rob_cm_ready), 32'd1);
        @(negedge clk);
        reset = 0;

        // Back-to-back writes take the first three free registers.
        for (int k = 1; k <= 3; k++) begin
            step(1, 5'(k + 4), 5'(k + 5), 5'(k), 1, 1, 0, 0, 0, 0, 0);
            chk("b2b_dis_prd", 32'(dis_prd), 32'(31 + k));
        end
        chk("b2b_stall_cnt", 32'(stall_cnt), 32'd0);

        // Drain the free list, then hold a write with nothing free.
        for (int k = 0; k < 29; k++)
            step(1, 5'($urandom), 5'($urandom), 5'((k % 31) + 1), 1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++)
            step(1, 5'd1, 5'd2, 5'd9, 1, 1, 0, 0, 0, 0, 0);
        chk("fl_stall_cnt", 32'(stall_cnt), 32'd5);
        step(1, 5'd1, 5'd2, 5'd9, 1, 1, 0, 2'b01, 2'b01, 6'd5, 6'd0);
        for (int k = 0; k < 12 && !m_dv; k++)
            step(1, 5'd1, 5'd2, 5'd9, 1, 1, 0, 0, 0, 0, 0);
        chk("fl_ret_dis_valid", 32'(dis_valid), 32'd1);
        chk("fl_ret_dis_prd",   32'(dis_prd),   32'd5);

        // Dispatch back-pressure holds the output.
        for (int k = 0; k < 3; k++)
            step(1, 5'd3, 5'd4, 5'd6, 0, 0, 0, 0, 0, 0, 0);
        step(1, 5'd3, 5'd4, 5'd6, 0, 1, 0, 0, 0, 0, 0);
        chk("bp_release_valid", 32'(dis_valid), 32'd1);

        // x0 destination fires even with an empty free list.
        step(1, 5'd7, 5'd8, 5'd0, 1, 1, 0, 0, 0, 0, 0);
        chk("x0_dis_valid",    32'(dis_valid),    32'd1);
        chk("x0_dis_regwrite", 32'(dis_regwrite), 32'd0);

        // Two-wide commit burst drains in order.
        step(1, 5'd1, 5'd1, 5'd2, 0, 1, 0, 2'b11, 2'b11, 6'd40, 6'd41);
        chk("burst_cm_idle", 32'(cm_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            if (k == 0) step(1, 5'd1, 5'd1, 5'd2, 0, 1, 0, 2'b11, 2'b11, 6'd42, 6'd43);
            else        step(1, 5'd1, 5'd1, 5'd2, 0, 1, 0, 0, 0, 0, 0);
            if (k == 0) chk("burst_ready_low", 32'(rob_cm_ready), 32'd0);
            chk("burst_cm_valid", 32'(cm_valid), 32'd1);
            chk("burst_cm_reg",   32'(cm_reg),   32'(exp_cm[k]));
        end

        // Flush while busy, then reset mid-drain.
        step(1, 5'd1, 5'd1, 5'd2, 0, 1, 0, 2'b11, 2'b11, 6'd44, 6'd45);
        step(1, 5'd1, 5'd1, 5'd2, 0, 1, 0, 2'b11, 2'b11, 6'd46, 6'd47);
        step(1, 5'd1, 5'd1, 5'd4, 1, 1, 1, 0, 0, 0, 0);
        chk("flush_dis_valid", 32'(dis_valid), 32'd0);
        chk("flush_cm_valid",  32'(cm_valid),  32'd1);
        chk("flush_cm_reg",    32'(cm_reg),    32'd45);
        #2;
        reset = 1;
        #1;
        chk("async_rst_cm_valid",  32'(cm_valid),  32'd0);
        chk("async_rst_dis_valid", 32'(dis_valid), 32'd0);
        chk("async_rst_stall",     32'(stall_cnt), 32'd0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        reset = 0;

        // Randomized traffic against the reference model.
        for (int k = 0; k < 400; k++)
            step(($urandom % 4) != 0, 5'($urandom), 5'($urandom), 5'($urandom),
                 1'($urandom), ($urandom % 4) != 0, ($urandom % 16) == 0,
                 2'($urandom), 2'($urandom),
                 6'(32 + $urandom % 32), 6'(32 + $urandom % 32));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rename_sched.md
Name: rename_sched

Overview:
- Sequences the register-rename resource (arch→phy map plus free-physical-register list) between decode and dispatch.
- Front side: accepts one decoded instruction per cycle over valid/ready, issues the rename request to the rename file, and registers the result toward dispatch.
- Stalls when the free list is empty or dispatch back-pressures.
- Back side: serializes up to two ROB commits per cycle onto the rename file's single commit port through a small queue.

Parameters:
- ARCH_REG_NUM_WIDTH, `ARCH_REG_NUM_WIDTH (5), bits of an architectural register index.
- PHYSICAL_REG_NUM_WIDTH, `PHYSICAL_REG_NUM_WIDTH (6), bits of a physical register index.
- COMMIT_Q_DEPTH, 4, commit queue entries; power of two, ≥2.
- STALL_CNT_WIDTH, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  squash the in-flight rename output; sync.
- dec_valid  in  1  decoded instruction valid.
- dec_ready  out  1  decode may advance.
- dec_rs1, dec_rs2, dec_rd  in  ARCH_REG_NUM_WIDTH each  architectural sources and destination.
- dec_regwrite  in  1  instruction writes rd.
- rf_read1, rf_read2, rf_write  out  ARCH_REG_NUM_WIDTH each  to the rename file, combinationally equal to dec_rs1/rs2/rd.
- rf_regwrite  out  1  allocate request; high only on a rename fire with a write.
- rf_prs1, rf_prs2, rf_prd  in  PHYSICAL_REG_NUM_WIDTH each  rename file results.
- rf_valid  in  1  free list non-empty.
- dis_valid  out  1  renamed instruction valid.
- dis_ready  in  1  dispatch accepts.
- dis_prs1, dis_prs2, dis_prd  out  PHYSICAL_REG_NUM_WIDTH each  renamed registers.
- dis_regwrite  out  1  renamed instruction writes prd.
- rob_cm_valid  in  2  per-slot commit valid; slot 0 is older.
- rob_cm_with_write  in  2  commit writes a register.
- rob_cm_reg  in  2×PHYSICAL_REG_NUM_WIDTH  committed physical destination.
- rob_cm_ready  out  1  queue can absorb two commits.
- cm_valid, cm_with_write  out  1 each  to the rename file's commit port.
- cm_reg  out  PHYSICAL_REG_NUM_WIDTH  committed register.
- stall_cnt  out  STALL_CNT_WIDTH  cycles in a stall state, saturating.

Behaviour:
- Reset (async) clears every output: dis_* = 0, cm_* = 0, stall_cnt = 0, queue empty, FSM = RUN.
- A write means dec_regwrite && dec_rd != 0; x0 is never renamed.
- Output slot is free when !dis_valid || dis_ready.
- Fire = dec_valid && slot free && (!write || rf_valid) && !flush.
- dec_ready = slot free && (!write || rf_valid) && !flush. It does not depend on dec_valid.
- rf_regwrite = fire && write. Never assert it without fire: the rename file pops on it.
- On fire, dis_* loads rf_prs1/rf_prs2/rf_prd and write next cycle (1-cycle latency), and dis_valid is set.
- If the slot is free without a fire, dis_valid clears.
- Hold: while dis_valid && !dis_ready, dis_* are stable.
- flush: dis_valid clears next cycle, no fire that cycle, FSM → RUN. The commit queue is unaffected.
- FSM is evaluated each cycle when not firing and dec_valid is high:
  - RUN → STALL_FL when the instruction is a write and !rf_valid.
  - RUN → STALL_DIS when the slot is not free.
  - STALL_FL → RUN when rf_valid.
  - STALL_DIS → RUN when dis_ready.
  - STALL_FL has priority if both conditions hold.
  - Any fire → RUN.
- stall_cnt increments each cycle in STALL_FL or STALL_DIS and saturates at all-ones.
- Commit queue enqueue:
  - Only entries with valid && with_write are enqueued; other commits are dropped.
  - Slot 0 is written before slot 1, so 0, 1 or 2 pushes per cycle.
  - Pushes occur only while rob_cm_ready = (free entries ≥ 2), evaluated on the registered count.
- Commit queue dequeue:
  - Pops one entry per cycle when non-empty; cm_valid = 1, cm_with_write = 1, cm_reg = head. Outputs are registered.
  - When empty, cm_valid = 0.
  - Push and pop in the same cycle are legal; count = count + pushes − pop.
  - Pointers wrap modulo COMMIT_Q_DEPTH.
  - Full plus a push is impossible because of rob_cm_ready; an assertion flags a violation.

Decomposition:
- Package ooo_rename_pkg holds:
  - typedefs arch_reg_t and phy_reg_t, sized from the width macros;
  - enum rs_state_t {RUN, STALL_FL, STALL_DIS};
  - constant ZERO_REG = 0.
- One sub-module, rename_commit_q: dual-push, single-pop FIFO with the registered count and the ≥2-free flag.

Test Plan:
- After reset, rename file with 32 free regs: 3 back-to-back writes (rd = 1, 2, 3) with dis_ready = 1 → dis_prd = 32, 33, 34 on cycles 1–3; stall_cnt = 0.
- Free list drained, rf_valid = 0, write pending → dec_ready = 0, rf_regwrite = 0, FSM = STALL_FL, stall_cnt counts 5 over 5 cycles. Then cm returns reg 5 → fire, dis_prd = 5.
- dis_ready = 0 for 3 cycles with a valid output → dis_* are stable and dec_ready = 0. dis_ready rises → the next instruction appears the following cycle.
- Instruction with rd = 0 and dec_regwrite = 1 while rf_valid = 0 → fires and rf_regwrite = 0.
- rob_cm_valid = 2'b11 for 2 cycles with regs (40, 41), (42, 43) → rob_cm_ready drops once fewer than 2 entries are free. cm_reg emits 40, 41, 42, 43 in order on consecutive cycles.
- flush while dis_valid = 1 and dec_valid = 1 → dis_valid = 0 next cycle, rf_regwrite = 0, and the queue keeps draining. An async reset mid-drain clears cm_valid immediately.
